// File: rtl/mips_pkg.sv
// Shared types for the MIPS core hazard logic: register width, forwarding
// select encodings and the per-stage shadow entry.
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
    logic                  load;
  } stage_entry_t;

  // EX also needs its own sources to drive the ALU operand forwarding.
  typedef struct packed {
    stage_entry_t          dst;
    logic [REG_ADDR_W-1:0] s_addr;
    logic [REG_ADDR_W-1:0] t_addr;
    logic                  uses_s;
    logic                  uses_t;
  } ex_entry_t;

  function automatic logic reg_match(input stage_entry_t e,
                                     input logic [REG_ADDR_W-1:0] r);
    return e.we && (e.addr == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding selector: a non-load MEM producer beats WB, otherwise
// the operand comes from the register file.
module hazard_fwd_sel
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_use,
  input  stage_entry_t          mem_entry,
  input  stage_entry_t          wb_entry,
  output logic [1:0]            sel
);

  // WB data is final regardless of whether it came from a load.
  logic unused_wb_load;
  assign unused_wb_load = wb_entry.load;

  always_comb begin
    sel = FWD_REG;
    if (src_use && reg_match(mem_entry, src_addr) && !mem_entry.load)
      sel = FWD_MEM;
    else if (src_use && reg_match(wb_entry, src_addr))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stalls, bubbles, flushes
// and forwarding selects. Optional stall/flush counters under HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W   = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_reg_s_addr,
  input  logic [REG_ADDR_W-1:0] id_reg_t_addr,
  input  logic                  id_uses_s,
  input  logic                  id_uses_t,
  input  logic                  id_is_branch,
  input  logic [REG_ADDR_W-1:0] id_reg_d_addr,
  input  logic                  id_reg_d_we,
  input  logic                  id_is_load,
  input  logic                  pc_we,
  input  logic                  mem_busy,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  pc_we_q,
  output logic [1:0]            fwd_s_id,
  output logic [1:0]            fwd_t_id,
  output logic [1:0]            fwd_a_ex,
  output logic [1:0]            fwd_b_ex
`ifdef HAZARD_STATS_EN
  , output logic [STAT_W-1:0]   stall_cycles
  , output logic [STAT_W-1:0]   flush_cnt
`endif
);

  import mips_pkg::*;

  ex_entry_t    ex_q;
  stage_entry_t mem_q;
  stage_entry_t wb_q;

  logic load_use;
  logic br_haz;
  logic hazard;
  logic stall;

  always_comb begin
    load_use = ex_q.dst.load &&
               ((id_uses_s && reg_match(ex_q.dst, id_reg_s_addr)) ||
                (id_uses_t && reg_match(ex_q.dst, id_reg_t_addr)));
    // A branch compares in ID, so any EX producer or a MEM load is too late.
    br_haz   = id_is_branch &&
               (reg_match(ex_q.dst, id_reg_s_addr) ||
                reg_match(ex_q.dst, id_reg_t_addr) ||
                (mem_q.load && (reg_match(mem_q, id_reg_s_addr) ||
                                reg_match(mem_q, id_reg_t_addr))));
    hazard   = load_use || br_haz;
    stall    = !rst && (mem_busy || hazard);
  end

  assign stall_id  = stall;
  assign stall_if  = stall;
  assign bubble_ex = !rst && hazard && !mem_busy;
  assign pc_we_q   = !rst && pc_we && !stall && !mem_busy;
  assign flush_id  = pc_we_q;

  // NOTE: state uses non-blocking assignments so every stage samples the
  // pre-edge value of its upstream neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.dst;
      if (hazard) begin
        ex_q <= '0;
      end else begin
        ex_q.dst.addr <= id_reg_d_addr;
        ex_q.dst.we   <= id_reg_d_we;
        ex_q.dst.load <= id_is_load;
        ex_q.s_addr   <= id_reg_s_addr;
        ex_q.t_addr   <= id_reg_t_addr;
        ex_q.uses_s   <= id_uses_s;
        ex_q.uses_t   <= id_uses_t;
      end
    end
  end

  hazard_fwd_sel u_fwd_s_id (
    .src_addr  (id_reg_s_addr),
    .src_use   (1'b1),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_s_id)
  );

  hazard_fwd_sel u_fwd_t_id (
    .src_addr  (id_reg_t_addr),
    .src_use   (1'b1),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_t_id)
  );

  hazard_fwd_sel u_fwd_a_ex (
    .src_addr  (ex_q.s_addr),
    .src_use   (ex_q.uses_s),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_a_ex)
  );

  hazard_fwd_sel u_fwd_b_ex (
    .src_addr  (ex_q.t_addr),
    .src_use   (ex_q.uses_t),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (fwd_b_ex)
  );

`ifdef HAZARD_STATS_EN
  // Saturating counters: a pegged value means "at least this many".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (hazard && !mem_busy && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (pc_we_q && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, all compared against an in-flight instruction model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_reg_s_addr, id_reg_t_addr, id_reg_d_addr;
  logic       id_uses_s, id_uses_t, id_is_branch, id_reg_d_we, id_is_load;
  logic       pc_we, mem_busy;
  logic       stall_if, stall_id, bubble_ex, flush_id, pc_we_q;
  logic [1:0] fwd_s_id, fwd_t_id, fwd_a_ex, fwd_b_ex;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_cnt;
`endif

  hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_reg_s_addr (id_reg_s_addr),
    .id_reg_t_addr (id_reg_t_addr),
    .id_uses_s     (id_uses_s),
    .id_uses_t     (id_uses_t),
    .id_is_branch  (id_is_branch),
    .id_reg_d_addr (id_reg_d_addr),
    .id_reg_d_we   (id_reg_d_we),
    .id_is_load    (id_is_load),
    .pc_we         (pc_we),
    .mem_busy      (mem_busy),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .flush_id      (flush_id),
    .pc_we_q       (pc_we_q),
    .fwd_s_id      (fwd_s_id),
    .fwd_t_id      (fwd_t_id),
    .fwd_a_ex      (fwd_a_ex),
    .fwd_b_ex      (fwd_b_ex)
`ifdef HAZARD_STATS_EN
    , .stall_cycles (stall_cycles)
    , .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // An instruction in flight; slot 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [4:0] d;
    bit         we;
    bit         ld;
    logic [4:0] s;
    logic [4:0] t;
    bit         us;
    bit         ut;
  } instr_t;

  instr_t      inflight[3];
  int unsigned m_stalls, m_flushes;
  int          n_checks, n_fail;
  bit          e_lu, e_bh, e_pcq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input instr_t i, input logic [4:0] r);
    return i.we && i.d == r && r != 5'd0;
  endfunction

  function automatic logic [1:0] exp_fwd_id(input logic [4:0] r);
    if (writes(inflight[1], r) && !inflight[1].ld) return 2'b01;
    if (writes(inflight[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_fwd_ex(input logic [4:0] r, input bit u);
    if (u && writes(inflight[1], r)) return 2'b01;
    if (u && writes(inflight[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic compare_model();
    instr_t ex, mm;
    bit     stall;
    ex = inflight[0];
    mm = inflight[1];
    e_lu  = ex.ld && ((id_uses_s && writes(ex, id_reg_s_addr)) ||
                      (id_uses_t && writes(ex, id_reg_t_addr)));
    e_bh  = id_is_branch && (writes(ex, id_reg_s_addr) || writes(ex, id_reg_t_addr) ||
            (mm.ld && (writes(mm, id_reg_s_addr) || writes(mm, id_reg_t_addr))));
    stall = mem_busy || e_lu || e_bh;
    e_pcq = pc_we && !stall;
    check("stall_if", stall_if, stall);
    check("stall_id", stall_id, stall);
    check("bubble_ex", bubble_ex, (e_lu || e_bh) && !mem_busy);
    check("pc_we_q", pc_we_q, e_pcq);
    check("flush_id", flush_id, e_pcq);
    check("fwd_s_id", fwd_s_id, exp_fwd_id(id_reg_s_addr));
    check("fwd_t_id", fwd_t_id, exp_fwd_id(id_reg_t_addr));
    check("fwd_a_ex", fwd_a_ex, exp_fwd_ex(inflight[0].s, inflight[0].us));
    check("fwd_b_ex", fwd_b_ex, exp_fwd_ex(inflight[0].t, inflight[0].ut));
`ifdef HAZARD_STATS_EN
    check("stall_cycles", stall_cycles, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (!mem_busy) begin
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      if (e_lu || e_bh) inflight[0] = '{default: 0};
      else inflight[0] = '{id_reg_d_addr, id_reg_d_we, id_is_load,
                           id_reg_s_addr, id_reg_t_addr, id_uses_s, id_uses_t};
      if (e_lu || e_bh) m_stalls++;
    end
    if (e_pcq) m_flushes++;
    @(negedge clk);
  endtask

  task automatic cycle();
    #1 compare_model();
    advance();
  endtask

  task automatic drive(input logic [4:0] s, input logic [4:0] t, input bit us, input bit ut,
                       input bit br, input logic [4:0] d, input bit we, input bit ld,
                       input bit pcw, input bit busy);
    id_reg_s_addr = s; id_reg_t_addr = t; id_uses_s = us; id_uses_t = ut;
    id_is_branch = br; id_reg_d_addr = d; id_reg_d_we = we; id_is_load = ld;
    pc_we = pcw; mem_busy = busy;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (3) cycle();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) inflight[i] = '{default: 0};
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_stall_id", stall_id, 0);
    check("rst_stall_if", stall_if, 0);
    check("rst_bubble", bubble_ex, 0);
    check("rst_pc_we_q", pc_we_q, 0);
    check("rst_flush", flush_id, 0);
    check("rst_fwd_a_ex", fwd_a_ex, 0);
`ifdef HAZARD_STATS_EN
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_model();
    drive(5'd2, 5'd2, 1, 1, 1, 5'd2, 1, 1, 1, 1);
    @(negedge clk);
    do_reset();
    nop();

    // Load-use: one bubble, then WB forwarding of the load result.
    drive(0, 0, 0, 0, 0, 5'd2, 1, 1, 0, 0); cycle();
    drive(5'd2, 0, 1, 0, 0, 5'd4, 1, 0, 0, 0);
    #1 check("lu_stall", stall_id, 1); check("lu_bubble", bubble_ex, 1);
    cycle();
    #1 check("lu_released", stall_id, 0); check("lu_fwd_a_bubble", fwd_a_ex, 0);
    cycle();
    nop();
    #1 check("lu_fwd_a_wb", fwd_a_ex, 2'b10);
    cycle();
    drain();

    // Branch with producer in MEM forwards; producer in EX stalls once.
    drive(0, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0); cycle();
    nop(); cycle();
    drive(5'd3, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    #1 check("br_mem_fwd", fwd_s_id, 2'b01); check("br_mem_nostall", stall_id, 0);
    cycle();
    drain();
    drive(0, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0); cycle();
    drive(5'd3, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    #1 check("br_ex_stall", stall_id, 1);
    cycle();
    #1 check("br_ex_after", stall_id, 0); check("br_ex_fwd", fwd_s_id, 2'b01);
    cycle();
    drain();

    // MEM beats WB; register 0 never forwards or stalls.
    drive(0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0); cycle();
    drive(5'd5, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
    nop();
    #1 check("prio_fwd_a", fwd_a_ex, 2'b01); check("prio_fwd_b", fwd_b_ex, 2'b01);
    cycle();
    drain();
    drive(0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0); cycle();
    drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    #1 check("r0_stall", stall_id, 0); check("r0_fwd_s", fwd_s_id, 0);
    cycle();
    drain();

    // Taken branch is held off while its operand is still in flight.
    drive(0, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0); cycle();
    drive(5'd7, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    #1 check("pcq_held", pc_we_q, 0); check("flush_held", flush_id, 0);
    cycle();
    #1 check("pcq_go", pc_we_q, 1); check("flush_go", flush_id, 1);
    cycle();
    drain();

    // mem_busy dominates a pending load-use.
    drive(0, 0, 0, 0, 0, 5'd2, 1, 1, 0, 0); cycle();
    drive(5'd2, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) begin
      #1 check("busy_stall", stall_if, 1); check("busy_nobubble", bubble_ex, 0);
      check("busy_pcq", pc_we_q, 0);
      cycle();
    end
    mem_busy = 1'b0;
    #1 check("busy_rel_bubble", bubble_ex, 1);
    cycle();
    #1 check("busy_rel_once", bubble_ex, 0);
    cycle();
    drain();

    // Reset during a load-use stall.
    drive(0, 0, 0, 0, 0, 5'd2, 1, 1, 0, 0); cycle();
    drive(5'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("pre_rst_stall", stall_id, 1);
    do_reset();
    #1 check("post_rst_stall", stall_id, 0);
    nop();

`ifdef HAZARD_STATS_EN
    repeat (4) begin
      drive(0, 0, 0, 0, 0, 5'd2, 1, 1, 0, 0); cycle();
      drive(5'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    end
    #1 check("stats_four", stall_cycles, 4);
    do_reset();
    nop();
`endif

    // Random streams over a small register set to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      bit we_r;
      we_r = $urandom_range(0, 1);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            we_r, we_r && ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, expected finish before 2000000");
    $fatal(1);
  end

endmodule
